// File: rtl/mips_if_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - fetch_state_e : fetch FSM states (run, halted, fault)
//   - PC_W, INST_W  : program counter and instruction widths
//   - INST_NOP      : value held in IF/ID after reset
//   - DEFAULT_RESET_PC : default byte address fetched after reset
//   - is_aligned()  : word-alignment test on the low address bits
package mips_if_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] INST_NOP         = 32'h0000_0000;
  localparam logic [PC_W-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StRun,
    StHalted,
    StFault
  } fetch_state_e;

  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture inst_i / pc_i and mark the entry valid
//   squash_i     : drop valid only; instruction and PCs are kept
//   inst_i, pc_i : fetched instruction and its byte address
//   valid_o, inst_o, pc_o, pc4_o : registered IF/ID contents
// With neither load_i nor squash_i asserted the register holds (stall).
module if_id_reg
  import mips_if_pkg::*;
#(
  parameter int unsigned DATA_W = INST_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              squash_i,
  input  logic [DATA_W-1:0] inst_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [PC_W-1:0]   pc4_o
);

  logic              valid_q;
  logic [DATA_W-1:0] inst_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc4_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      inst_q  <= DATA_W'(INST_NOP);
      pc_q    <= '0;
      pc4_q   <= '0;
    end else if (squash_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      pc4_q   <= pc_i + PC_W'(4);
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction ROM and loads the IF/ID register.
// Ports:
//   clk, rst (sync, active-high)
//   stall, redirect_valid/redirect_target, halt_req, resume : control in
//   rom_addr, rom_sel / rom_data : ROM word address, select, read data
//   if_id_valid, if_id_inst, if_id_pc, if_id_pc4 : IF/ID contents
//   halted, fault : current FSM state flags
//   fetch_count : count of valid IF/ID loads, only when INST_FETCH_PERF_EN
//                 is defined
module inst_fetch
  import mips_if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     ADDR_W   = 10,
  parameter int unsigned     DATA_W   = INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_sel,
  input  logic [DATA_W-1:0] rom_data,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_inst,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_pc4,
  output logic              halted,
  output logic              fault
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            load, squash;
  logic            target_ok;

  assign target_ok = is_aligned(redirect_target[1:0]);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    squash  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (redirect_valid) begin
          // Squash the wrong-path fetch even when stalled.
          squash = 1'b1;
          if (target_ok) pc_d = redirect_target;
          else           state_d = StFault;
        end else if (halt_req) begin
          squash  = 1'b1;
          state_d = StHalted;
        end else if (!stall) begin
          load = 1'b1;
          pc_d = pc_q + PC_W'(4);
        end
      end
      StHalted: begin
        squash = 1'b1;
        if (redirect_valid && !target_ok) begin
          state_d = StFault;
        end else begin
          if (redirect_valid) pc_d = redirect_target;
          if (resume)         state_d = StRun;
        end
      end
      StFault: begin
        squash = 1'b1;
      end
      default: begin
        squash  = 1'b1;
        state_d = StFault;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign rom_sel  = (state_q == StRun) && !stall;
  // ROM aliases every 2**(ADDR_W+2) bytes; no range check.
  assign rom_addr = pc_q[ADDR_W+1:2];
  assign halted   = (state_q == StHalted);
  assign fault    = (state_q == StFault);

  if_id_reg #(
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (load),
    .squash_i (squash),
    .inst_i   (rom_data),
    .pc_i     (pc_q),
    .valid_o  (if_id_valid),
    .inst_o   (if_id_inst),
    .pc_o     (if_id_pc),
    .pc4_o    (if_id_pc4)
  );

`ifdef INST_FETCH_PERF_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst)       fetch_count_q <= '0;
    else if (load) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
